// File: rtl/conv_encoder_tx.sv
// Rate-1/2 feed-forward convolutional encoder that appends M=K-1 zero tail bits after every frame.
// Define CONV_ENC_ERR_INJ_EN to add the err_mask port, which XORs channel errors into each loaded symbol.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | accepting data bits, one symbol per accepted bit
// TAIL  | flushing M zero bits to return the trellis to state 0
module conv_encoder_tx #(
    parameter int             K      = 3,
    parameter logic [K-1:0]   G0_OCT = 3'o7,
    parameter logic [K-1:0]   G1_OCT = 3'o5,
    parameter int             CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_in_valid,
    input  logic             bit_in_last,
    output logic             bit_in_ready,
    output logic [1:0]       tx_sym,
    output logic             tx_sym_valid,
    input  logic             tx_sym_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_bits
`ifdef CONV_ENC_ERR_INJ_EN
    ,
    input  logic [1:0]       err_mask
`endif
);

    localparam int M  = K - 1;
    localparam int TW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {RUN, TAIL} state_t;

    state_t             state_q, state_d;
    logic [M-1:0]       enc_state, enc_state_d;
    logic [TW-1:0]      tail_cnt, tail_cnt_d;
    logic [1:0]         tx_sym_d;
    logic               tx_sym_valid_d;
    logic [CNT_W-1:0]   frame_bits_d;
    logic               new_frame, new_frame_d;
    logic               out_free;
    logic               accept;
    logic [1:0]         inj;

`ifdef CONV_ENC_ERR_INJ_EN
    assign inj = err_mask;
`else
    assign inj = 2'b00;
`endif

    // sr[K-1] is the oldest state bit, sr[0] the incoming bit
    function automatic logic [1:0] encode(input logic [M-1:0] st, input logic b);
        logic [K-1:0] sr;
        sr = {st, b};
        return {^(sr & G0_OCT), ^(sr & G1_OCT)};
    endfunction

    assign out_free     = !tx_sym_valid || tx_sym_ready;
    assign bit_in_ready = (state_q == RUN) && out_free;
    assign accept       = bit_in_valid && bit_in_ready;
    assign busy         = (state_q == TAIL) || tx_sym_valid;

    always_comb begin
        state_d        = state_q;
        enc_state_d    = enc_state;
        tail_cnt_d     = tail_cnt;
        tx_sym_d       = tx_sym;
        tx_sym_valid_d = tx_sym_valid;
        frame_bits_d   = frame_bits;
        new_frame_d    = new_frame;

        if (tx_sym_ready)
            tx_sym_valid_d = 1'b0;

        case (state_q)
            RUN: begin
                if (accept) begin
                    tx_sym_d       = encode(enc_state, bit_in) ^ inj;
                    tx_sym_valid_d = 1'b1;
                    enc_state_d    = {enc_state[M-2:0], bit_in};
                    new_frame_d    = 1'b0;
                    if (new_frame)
                        frame_bits_d = CNT_W'(1);
                    else if (frame_bits != '1)
                        frame_bits_d = frame_bits + CNT_W'(1);
                    if (bit_in_last) begin
                        state_d    = TAIL;
                        tail_cnt_d = '0;
                    end
                end
            end
            TAIL: begin
                if (out_free) begin
                    tx_sym_d       = encode(enc_state, 1'b0) ^ inj;
                    tx_sym_valid_d = 1'b1;
                    enc_state_d    = {enc_state[M-2:0], 1'b0};
                    tail_cnt_d     = tail_cnt + TW'(1);
                    if (tail_cnt == TW'(M - 1)) begin
                        state_d     = RUN;
                        new_frame_d = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            enc_state    <= '0;
            tail_cnt     <= '0;
            tx_sym       <= 2'b00;
            tx_sym_valid <= 1'b0;
            frame_bits   <= '0;
            new_frame    <= 1'b1;
        end else begin
            state_q      <= state_d;
            enc_state    <= enc_state_d;
            tail_cnt     <= tail_cnt_d;
            tx_sym       <= tx_sym_d;
            tx_sym_valid <= tx_sym_valid_d;
            frame_bits   <= frame_bits_d;
            new_frame    <= new_frame_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed bench for conv_encoder_tx (K=3, G0=7, G1=5); symbols are collected as they are taken.
// Build with CONV_ENC_ERR_INJ_EN to also exercise the err_mask port.
module tb_conv_encoder_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        bit_in_valid;
    logic        bit_in_last;
    logic        bit_in_ready;
    logic [1:0]  tx_sym;
    logic        tx_sym_valid;
    logic        tx_sym_ready;
    logic        busy;
    logic [15:0] frame_bits;
`ifdef CONV_ENC_ERR_INJ_EN
    logic [1:0]  err_mask = 2'b00;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int inj_idx   = -1;
    logic [1:0] got[$];

    logic [1:0] exp_t1 [10] = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11};
    logic [1:0] exp_t2 [3]  = '{2'b11, 2'b10, 2'b11};
    logic [1:0] exp_t3 [6]  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic [1:0] exp_t4 [7]  = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11};

    conv_encoder_tx dut (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_in_valid (bit_in_valid),
        .bit_in_last  (bit_in_last),
        .bit_in_ready (bit_in_ready),
        .tx_sym       (tx_sym),
        .tx_sym_valid (tx_sym_valid),
        .tx_sym_ready (tx_sym_ready),
        .busy         (busy),
        .frame_bits   (frame_bits)
`ifdef CONV_ENC_ERR_INJ_EN
        ,
        .err_mask     (err_mask)
`endif
    );

    always #5 clk = ~clk;

    // Inputs only change 2ns after a rising edge, so a negedge sample shows what the next edge takes
    always @(negedge clk)
        if (!rst && tx_sym_valid && tx_sym_ready)
            got.push_back(tx_sym);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive_frame(input logic [15:0] bits, input int n);
        logic acc;
        logic timed_out;
        int   t;
        timed_out = 1'b0;
        for (int i = 0; i < n; i++) begin
            bit_in       = bits[i];
            bit_in_valid = 1'b1;
            bit_in_last  = (i == n - 1);
`ifdef CONV_ENC_ERR_INJ_EN
            err_mask = (i == inj_idx) ? 2'b01 : 2'b00;
`endif
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 50) begin
                @(negedge clk);
                acc = bit_in_ready;
                @(posedge clk);
                #2;
                t++;
            end
            if (!acc) timed_out = 1'b1;
        end
        bit_in_valid = 1'b0;
        bit_in_last  = 1'b0;
`ifdef CONV_ENC_ERR_INJ_EN
        err_mask = 2'b00;
`endif
        total_cnt++;
        if (timed_out) $display("FAIL accept_timeout: got stuck=%0b required stuck=0", timed_out);
        else pass_cnt++;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 100);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%0b required 0", busy);
        else pass_cnt++;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bit_in       = 1'b0;
        bit_in_valid = 1'b0;
        bit_in_last  = 1'b0;
        tx_sym_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (tx_sym_valid !== 1'b0) $display("FAIL rst_valid: got %0b required 0", tx_sym_valid); else pass_cnt++;
        total_cnt++;
        if (tx_sym !== 2'b00) $display("FAIL rst_sym: got %b required 00", tx_sym); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %0b required 0", busy); else pass_cnt++;
        total_cnt++;
        if (bit_in_ready !== 1'b1) $display("FAIL rst_ready: got %0b required 1", bit_in_ready); else pass_cnt++;
        total_cnt++;
        if (frame_bits !== 16'd0) $display("FAIL rst_frame_bits: got %0d required 0", frame_bits); else pass_cnt++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic test_alternating();
        logic [1:0] obs;
        got.delete();
        drive_frame(16'h00AA, 8);
        wait_idle();
        total_cnt++;
        if (got.size() != 10) $display("FAIL alt_count: got %0d required 10", got.size()); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            obs = (i < got.size()) ? got[i] : 2'bxx;
            total_cnt++;
            if (obs !== exp_t1[i]) $display("FAIL alt_sym[%0d]: got %b required %b", i, obs, exp_t1[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (frame_bits !== 16'd8) $display("FAIL alt_frame_bits: got %0d required 8", frame_bits); else pass_cnt++;
    endtask

    task automatic test_single_bit();
        logic [1:0] obs;
        int low_cnt;
        got.delete();
        low_cnt = 0;
        drive_frame(16'h0001, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!bit_in_ready) low_cnt++;
            @(posedge clk);
            #2;
        end
        wait_idle();
        total_cnt++;
        if (low_cnt != 2) $display("FAIL single_ready_low: got %0d cycles required 2", low_cnt); else pass_cnt++;
        total_cnt++;
        if (got.size() != 3) $display("FAIL single_count: got %0d required 3", got.size()); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            obs = (i < got.size()) ? got[i] : 2'bxx;
            total_cnt++;
            if (obs !== exp_t2[i]) $display("FAIL single_sym[%0d]: got %b required %b", i, obs, exp_t2[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (frame_bits !== 16'd1) $display("FAIL single_frame_bits: got %0d required 1", frame_bits); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [1:0] obs;
        int bad_sym, bad_vld, bad_rdy;
        got.delete();
        bad_sym = 0;
        bad_vld = 0;
        bad_rdy = 0;
        fork
            drive_frame(16'h000D, 4);
            begin
                repeat (2) @(posedge clk);
                #2;
                tx_sym_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (tx_sym !== 2'b10) bad_sym++;
                    if (tx_sym_valid !== 1'b1) bad_vld++;
                    if (bit_in_ready !== 1'b0) bad_rdy++;
                    @(posedge clk);
                    #2;
                end
                tx_sym_ready = 1'b1;
            end
        join
        wait_idle();
        total_cnt++;
        if (bad_sym != 0) $display("FAIL stall_sym_hold: got %0d bad cycles required 0", bad_sym); else pass_cnt++;
        total_cnt++;
        if (bad_vld != 0) $display("FAIL stall_valid_hold: got %0d bad cycles required 0", bad_vld); else pass_cnt++;
        total_cnt++;
        if (bad_rdy != 0) $display("FAIL stall_ready_low: got %0d bad cycles required 0", bad_rdy); else pass_cnt++;
        total_cnt++;
        if (got.size() != 6) $display("FAIL stall_count: got %0d required 6", got.size()); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            obs = (i < got.size()) ? got[i] : 2'bxx;
            total_cnt++;
            if (obs !== exp_t3[i]) $display("FAIL stall_sym[%0d]: got %b required %b", i, obs, exp_t3[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] obs;
        got.delete();
        drive_frame(16'h0003, 2);
        total_cnt++;
        if (frame_bits !== 16'd2) $display("FAIL b2b_frame_bits_a: got %0d required 2", frame_bits); else pass_cnt++;
        drive_frame(16'h0001, 1);
        wait_idle();
        total_cnt++;
        if (frame_bits !== 16'd1) $display("FAIL b2b_frame_bits_b: got %0d required 1", frame_bits); else pass_cnt++;
        total_cnt++;
        if (got.size() != 7) $display("FAIL b2b_count: got %0d required 7", got.size()); else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            obs = (i < got.size()) ? got[i] : 2'bxx;
            total_cnt++;
            if (obs !== exp_t4[i]) $display("FAIL b2b_sym[%0d]: got %b required %b", i, obs, exp_t4[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_tail();
        logic [1:0] obs;
        got.delete();
        drive_frame(16'h00AA, 8);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (tx_sym_valid !== 1'b0) $display("FAIL abort_valid: got %0b required 0", tx_sym_valid); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %0b required 0", busy); else pass_cnt++;
        total_cnt++;
        if (got.size() != 8) $display("FAIL abort_count: got %0d required 8", got.size()); else pass_cnt++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        got.delete();
        drive_frame(16'h0001, 1);
        wait_idle();
        total_cnt++;
        if (got.size() != 3) $display("FAIL abort_new_count: got %0d required 3", got.size()); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            obs = (i < got.size()) ? got[i] : 2'bxx;
            total_cnt++;
            if (obs !== exp_t2[i]) $display("FAIL abort_new_sym[%0d]: got %b required %b", i, obs, exp_t2[i]);
            else pass_cnt++;
        end
    endtask

`ifdef CONV_ENC_ERR_INJ_EN
    task automatic test_err_inj();
        logic [1:0] obs;
        logic [1:0] want;
        got.delete();
        inj_idx = 2;
        drive_frame(16'h00AA, 8);
        inj_idx = -1;
        wait_idle();
        total_cnt++;
        if (got.size() != 10) $display("FAIL inj_count: got %0d required 10", got.size()); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            obs  = (i < got.size()) ? got[i] : 2'bxx;
            want = (i == 2) ? 2'b11 : exp_t1[i];
            total_cnt++;
            if (obs !== want) $display("FAIL inj_sym[%0d]: got %b required %b", i, obs, want);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alternating();
        test_single_bit();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_tail();
`ifdef CONV_ENC_ERR_INJ_EN
        test_err_inj();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
